float_addsub_p: RTL and testbench
=================================

# float_addsub_p

Parametrised, fully pipelined floating-point adder/subtractor with per-operand signs, add/sub mode, valid/tag sideband, clock enable and IEEE-style special-value handling. Successor to the fixed single-precision adder in the float datapath: generic exponent/mantissa widths, a true signed add/sub and a registered valid pipeline. It sits between operand-fetch and result-writeback stages of the float units; one operation accepted per enabled cycle, no backpressure.

## Interface
- EW, 8, exponent width (≥3)
- MW, 23, stored mantissa width (≥4); word width W = 1+EW+MW
- TW, 4, tag width, carried unchanged alongside each operation
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- ce  in  1  clock enable; 0 freezes every pipeline register
- in_valid  in  1  operation present on a, b, sub, in_tag
- a  in  W  operand A {sign, exp, mant}
- b  in  W  operand B
- sub  in  1  1: compute a − b; 0: a + b
- in_tag  in  TW  user tag
- out_valid  out  1  result present
- res  out  W  result
- out_tag  out  TW  tag of the operation in res

## Operation
- Effective B sign = b.sign XOR sub. exp==0 means zero (denormals flushed to zero, sign kept).
- S1 classify/swap: compare {exp,mant} magnitudes; larger → big, equal → A is big. Flags: nan (either exp all-ones with mant≠0, or inf − inf of opposite effective signs), inf (either exp all-ones, mant==0).
- S2: dexp = e_big − e_small (EW bits, unsigned); rsign = big.sign; eff_sub = big.sign XOR small.sign.
- S3 align: small significand {hidden,mant} (MW+1 bits, hidden=0 if zero) shifted right by dexp; dexp > MW → 0. Truncation, no guard/sticky bits.
- S4: r = big ± small on MW+2 bits (carry bit on top).
- S5 normalise (sub-module): r==0 → +0. r[MW+1]=1 → shift right 1, exp+1. Else lz = leading zeros of r[MW:0]; shift left lz, exp − lz (signed, EW+1 bits).
- S6 pack: nan → {0, all-ones, 1 at mant MSB, rest 0}. inf → {inf sign, all-ones, 0}. exp ≥ all-ones → {rsign, all-ones, 0} (overflow to inf). exp ≤ 0 → {rsign, 0, 0}. Else {rsign, exp[EW-1:0], mant without hidden bit}.
- Rounding: toward zero (truncate) everywhere.
- Exact cancellation gives +0 regardless of signs.
- Data registers advance regardless of in_valid; only valid/tag semantics matter at output.

## Timing
- Latency 6 enabled cycles: in_valid=1 sampled at enabled edge n → out_valid=1 with res/out_tag after enabled edge n+6.
- Throughput 1/enabled cycle; back-to-back operations never interfere.
- ce=0: all stage registers, out_valid, res, out_tag hold; input ignored that cycle.
- rst (priority over ce): all valid bits in every stage, out_valid, res, out_tag cleared to 0 on the next edge; in-flight operations discarded. First valid output after reset deassertion no earlier than 6 enabled cycles after accept.
- in_valid during rst cycle is dropped.

## Structure
- Package float_pkg: localparams/functions for field extraction (sign/exp/mant of W), canonical qNaN and inf constructors, a stage-payload struct typedef parameterised via EW/MW widths.
- One sub-module: float_lzc_norm (MW+2-bit input, outputs lz count and left-shifted significand), combinational, instantiated in S5; its input and outputs registered by the parent.
- Six stage register banks in the parent, each carrying valid, tag and special flags.

## Test plan
- EW=8, MW=23: a=0x3F800000, b=0x40000000, sub=0, tag=3 → after 6 cycles res=0x40400000, out_tag=3.
- a=0x3FC00000, b=0xBF000000, sub=0 → 0x3F800000; a=b=0x3F800000, sub=1 → 0x00000000; a=0x3F800000, b=0x33800000 → 0x3F800000 (truncation).
- a=b=0x7F7FFFFF, sub=0 → 0x7F800000; a=b=0x7F800000, sub=1 → 0x7FC00000; a=0xFF800000, b=0x3F800000 → 0xFF800000.
- Ten back-to-back ops, tags 0..9, ce low 3 cycles mid-stream → outputs in order, held during ce=0, each latency 6 enabled cycles.
- rst for 1 cycle with 4 ops in flight → out_valid=0, res=0 next cycle; no stale result appears afterwards; new op after reset completes normally.
- EW=5, MW=10 (half precision): 0x3C00 + 0x4000 → 0x4200; 0x7BFF + 0x7BFF → 0x7C00.

Source files
------------

// File: rtl/float_pkg.sv
// Shared definitions for the float datapath units.
//   - special_t   : special-value flags that ride along the adder pipeline
//   - f_sign/f_exp/f_mant : field extraction from a {sign, exp, mant} word
//   - f_inf/f_qnan : canonical infinity / quiet-NaN constructors
// Words are handled zero-extended to MAXW bits so one set of helpers
// serves every EW/MW combination; callers narrow the result with a size cast.
package float_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic nan;
    logic inf;
    logic inf_sign;
  } special_t;

  function automatic logic f_sign(input logic [MAXW-1:0] x, input int ew, input int mw);
    return x[ew+mw];
  endfunction

  function automatic logic [MAXW-1:0] f_exp(input logic [MAXW-1:0] x, input int ew, input int mw);
    return (x >> mw) & ((MAXW'(1) << ew) - MAXW'(1));
  endfunction

  function automatic logic [MAXW-1:0] f_mant(input logic [MAXW-1:0] x, input int mw);
    return x & ((MAXW'(1) << mw) - MAXW'(1));
  endfunction

  function automatic logic [MAXW-1:0] f_inf(input logic s, input int ew, input int mw);
    return (MAXW'(s) << (ew + mw)) | (((MAXW'(1) << ew) - MAXW'(1)) << mw);
  endfunction

  function automatic logic [MAXW-1:0] f_qnan(input int ew, input int mw);
    return f_inf(1'b0, ew, mw) | (MAXW'(1) << (mw - 1));
  endfunction

endpackage

// File: rtl/float_lzc_norm.sv
// Normalisation helper for the adder: counts leading zeros of the sum
// below the carry bit and returns the significand shifted into place.
//   i_r   : MW+2-bit raw sum {carry, hidden, mant}
//   o_lz  : left-shift amount (0 when the carry bit is set)
//   o_sig : normalised MW+1-bit significand (right-shifted by one on carry)
// Purely combinational; the parent registers both sides.
module float_lzc_norm #(
  parameter int MW  = 23,
  parameter int LZW = $clog2(MW + 1)
) (
  input  logic [MW+1:0]  i_r,
  output logic [LZW-1:0] o_lz,
  output logic [MW:0]    o_sig
);

  always_comb begin
    o_lz = '0;
    // Scanning upward lets the highest set bit win.
    for (int i = 0; i <= MW; i++) begin
      if (i_r[i]) o_lz = LZW'(MW - i);
    end
    if (i_r[MW+1]) begin
      o_lz  = '0;
      o_sig = i_r[MW+1:1];
    end else begin
      o_sig = i_r[MW:0] << o_lz;
    end
  end

endmodule

// File: rtl/float_addsub_p.sv
// Six-cycle pipelined floating-point adder/subtractor, truncating rounding,
// denormals flushed to zero, NaN/infinity handling.
//   clk, rst (sync, active-high), ce (freezes the whole pipe when low)
//   in_valid, a, b, sub, in_tag : operation in ({sign, exp, mant} words)
//   out_valid, res, out_tag     : result, tag travels unchanged
// Bank p0 captures operands; p1..p5 hold stages S1..S5; res is S6.
module float_addsub_p
  import float_pkg::*;
#(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int TW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ce,
  input  logic            in_valid,
  input  logic [EW+MW:0]  a,
  input  logic [EW+MW:0]  b,
  input  logic            sub,
  input  logic [TW-1:0]   in_tag,
  output logic            out_valid,
  output logic [EW+MW:0]  res,
  output logic [TW-1:0]   out_tag
);

  localparam int W   = 1 + EW + MW;
  localparam int SW  = MW + 1;
  localparam int RW  = MW + 2;
  localparam int LZW = $clog2(MW + 1);
  localparam int XW  = EW + LZW + 2;  // room for exp+1 and exp-lz without wrap

  localparam logic [EW-1:0]        EMAX   = '1;
  localparam logic [W-1:0]         QNAN   = W'(f_qnan(EW, MW));
  localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);
  localparam logic signed [XW-1:0] ZERO_X = '0;

  // Final packing, including overflow saturation to infinity and
  // underflow flush to signed zero.
  function automatic logic [W-1:0] f_pack(input special_t sp, input logic zero, input logic s,
                                          input logic signed [XW-1:0] e, input logic [SW-1:0] sig);
    if (sp.nan) return QNAN;
    if (sp.inf) return W'(f_inf(sp.inf_sign, EW, MW));
    if (zero) return '0;
    if (e >= EMAX_X) return W'(f_inf(s, EW, MW));
    if (e <= ZERO_X) return {s, {(EW+MW){1'b0}}};
    return {s, e[EW-1:0], sig[MW-1:0]};
  endfunction

  logic              r_vld_p0, r_vld_p1, r_vld_p2, r_vld_p3, r_vld_p4, r_vld_p5;
  logic [TW-1:0]     r_tag_p0, r_tag_p1, r_tag_p2, r_tag_p3, r_tag_p4, r_tag_p5;
  logic [W-1:0]      r_a_p0, r_b_p0, r_big_p1, r_small_p1;
  special_t          r_spec_p1, r_spec_p2, r_spec_p3, r_spec_p4, r_spec_p5;
  logic [EW-1:0]     r_dexp_p2, r_ebig_p2, r_ebig_p3, r_ebig_p4;
  logic [SW-1:0]     r_sigb_p2, r_sigs_p2, r_sigb_p3, r_sigs_p3, r_sig_p5;
  logic              r_rsign_p2, r_rsign_p3, r_rsign_p4, r_rsign_p5;
  logic              r_effsub_p2, r_effsub_p3, r_zero_p5;
  logic [RW-1:0]     r_r_p4;
  logic signed [XW-1:0] r_exp_p5;

  // ---- S1: classify and order operands ----
  logic [MAXW-1:0] w_ax, w_bx;
  logic [EW-1:0]   w_ea, w_eb;
  logic [MW-1:0]   w_ma, w_mb;
  logic            w_sa, w_sb, w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_big;
  special_t        w_spec1;

  assign w_ax    = MAXW'(r_a_p0);
  assign w_bx    = MAXW'(r_b_p0);
  assign w_sa    = f_sign(w_ax, EW, MW);
  assign w_sb    = f_sign(w_bx, EW, MW);
  assign w_ea    = EW'(f_exp(w_ax, EW, MW));
  assign w_eb    = EW'(f_exp(w_bx, EW, MW));
  // exp==0 is zero: dropping the mantissa flushes denormals
  assign w_ma    = (w_ea == '0) ? '0 : MW'(f_mant(w_ax, MW));
  assign w_mb    = (w_eb == '0) ? '0 : MW'(f_mant(w_bx, MW));
  assign w_a_nan = (w_ea == EMAX) && (w_ma != '0);
  assign w_b_nan = (w_eb == EMAX) && (w_mb != '0);
  assign w_a_inf = (w_ea == EMAX) && (w_ma == '0);
  assign w_b_inf = (w_eb == EMAX) && (w_mb == '0);
  assign w_a_big = {w_ea, w_ma} >= {w_eb, w_mb};

  always_comb begin
    w_spec1.nan      = w_a_nan | w_b_nan | (w_a_inf & w_b_inf & (w_sa != w_sb));
    w_spec1.inf      = (w_a_inf | w_b_inf) & ~w_spec1.nan;
    w_spec1.inf_sign = w_a_inf ? w_sa : w_sb;
  end

  // ---- S2: exponent difference, result sign ----
  logic [EW-1:0] w_eb1, w_es1;
  assign w_eb1 = r_big_p1[W-2:MW];
  assign w_es1 = r_small_p1[W-2:MW];

  // ---- S3: align smaller significand (truncating) ----
  logic [SW-1:0] w_sigs3;
  assign w_sigs3 = (32'(r_dexp_p2) > 32'(MW)) ? '0 : (r_sigs_p2 >> r_dexp_p2);

  // ---- S4: magnitude add/subtract; big >= small so no sign flip ----
  logic [RW-1:0] w_r4;
  assign w_r4 = r_effsub_p3 ? ({1'b0, r_sigb_p3} - {1'b0, r_sigs_p3})
                            : ({1'b0, r_sigb_p3} + {1'b0, r_sigs_p3});

  // ---- S5: normalise ----
  logic [LZW-1:0]       w_lz5;
  logic [SW-1:0]        w_sig5;
  logic signed [XW-1:0] w_ebig5, w_lz5_x, w_exp5;

  float_lzc_norm #(.MW(MW), .LZW(LZW)) u_lzc (
    .i_r   (r_r_p4),
    .o_lz  (w_lz5),
    .o_sig (w_sig5)
  );

  assign w_ebig5 = $signed(XW'(r_ebig_p4));
  assign w_lz5_x = $signed(XW'(w_lz5));
  assign w_exp5  = r_r_p4[MW+1] ? (w_ebig5 + ONE_X) : (w_ebig5 - w_lz5_x);

  // Valid chain: reset wins over ce and drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld_p0  <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_vld_p2  <= 1'b0;
      r_vld_p3  <= 1'b0;
      r_vld_p4  <= 1'b0;
      r_vld_p5  <= 1'b0;
      out_valid <= 1'b0;
    end else if (ce) begin
      r_vld_p0  <= in_valid;
      r_vld_p1  <= r_vld_p0;
      r_vld_p2  <= r_vld_p1;
      r_vld_p3  <= r_vld_p2;
      r_vld_p4  <= r_vld_p3;
      r_vld_p5  <= r_vld_p4;
      out_valid <= r_vld_p5;
    end
  end

  // Data path registers advance on every enabled cycle.
  always_ff @(posedge clk) begin
    if (ce) begin
      r_a_p0      <= a;
      r_b_p0      <= {b[W-1] ^ sub, b[W-2:0]};
      r_tag_p0    <= in_tag;
      r_big_p1    <= w_a_big ? {w_sa, w_ea, w_ma} : {w_sb, w_eb, w_mb};
      r_small_p1  <= w_a_big ? {w_sb, w_eb, w_mb} : {w_sa, w_ea, w_ma};
      r_spec_p1   <= w_spec1;
      r_tag_p1    <= r_tag_p0;
      r_dexp_p2   <= w_eb1 - w_es1;
      r_ebig_p2   <= w_eb1;
      r_sigb_p2   <= {w_eb1 != '0, r_big_p1[MW-1:0]};
      r_sigs_p2   <= {w_es1 != '0, r_small_p1[MW-1:0]};
      r_rsign_p2  <= r_big_p1[W-1];
      r_effsub_p2 <= r_big_p1[W-1] ^ r_small_p1[W-1];
      r_spec_p2   <= r_spec_p1;
      r_tag_p2    <= r_tag_p1;
      r_sigb_p3   <= r_sigb_p2;
      r_sigs_p3   <= w_sigs3;
      r_ebig_p3   <= r_ebig_p2;
      r_rsign_p3  <= r_rsign_p2;
      r_effsub_p3 <= r_effsub_p2;
      r_spec_p3   <= r_spec_p2;
      r_tag_p3    <= r_tag_p2;
      r_r_p4      <= w_r4;
      r_ebig_p4   <= r_ebig_p3;
      r_rsign_p4  <= r_rsign_p3;
      r_spec_p4   <= r_spec_p3;
      r_tag_p4    <= r_tag_p3;
      r_sig_p5    <= w_sig5;
      r_exp_p5    <= w_exp5;
      r_zero_p5   <= (r_r_p4 == '0);
      r_rsign_p5  <= r_rsign_p4;
      r_spec_p5   <= r_spec_p4;
      r_tag_p5    <= r_tag_p4;
    end
  end

  // ---- S6: pack into the output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      res     <= '0;
      out_tag <= '0;
    end else if (ce) begin
      res     <= f_pack(r_spec_p5, r_zero_p5, r_rsign_p5, r_exp_p5, r_sig_p5);
      out_tag <= r_tag_p5;
    end
  end

endmodule

// File: tb/tb_float_addsub_p.sv
module tb_float_addsub_p;

  typedef struct {
    logic [31:0] res;
    logic [3:0]  tag;
    int          stamp;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, ce, in_valid, sub, out_valid;
  logic [31:0] a, b, res;
  logic [3:0]  in_tag, out_tag;

  logic        ce_h, in_valid_h, sub_h, out_valid_h;
  logic [15:0] a_h, b_h, res_h;
  logic [3:0]  in_tag_h, out_tag_h;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   en_cnt  = 0;
  exp_t q_s[$];
  exp_t q_h[$];

  float_addsub_p #(.EW(8), .MW(23), .TW(4)) dut (
    .clk(clk), .rst(rst), .ce(ce), .in_valid(in_valid), .a(a), .b(b), .sub(sub),
    .in_tag(in_tag), .out_valid(out_valid), .res(res), .out_tag(out_tag)
  );

  float_addsub_p #(.EW(5), .MW(10), .TW(4)) dut_h (
    .clk(clk), .rst(rst), .ce(ce_h), .in_valid(in_valid_h), .a(a_h), .b(b_h), .sub(sub_h),
    .in_tag(in_tag_h), .out_valid(out_valid_h), .res(res_h), .out_tag(out_tag_h)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", nm, act, req);
    end
  endtask

  // Reference: value-level add following the documented rules
  // (flush, align with truncation, add, renormalise by repeated halving/doubling).
  function automatic logic [63:0] ref_add(input logic [63:0] x, input logic [63:0] y,
                                          input logic s, input int ew, input int mw);
    longint emax, mmask, one, sx, sy, ex, ey, mx, my, qnan;
    longint sbig, ebig, sigbig, ssm, esm, sigsm, d, r, e;
    one   = longint'(1);
    emax  = (one << ew) - 1;
    mmask = (one << mw) - 1;
    qnan  = (emax << mw) | (one << (mw - 1));
    sx = longint'(x[ew+mw]);
    sy = longint'(y[ew+mw] ^ s);
    ex = longint'(x >> mw) & emax;
    ey = longint'(y >> mw) & emax;
    mx = (ex == 0) ? 0 : (longint'(x) & mmask);
    my = (ey == 0) ? 0 : (longint'(y) & mmask);
    if ((ex == emax && mx != 0) || (ey == emax && my != 0)) return qnan;
    if (ex == emax && ey == emax && sx != sy) return qnan;
    if (ex == emax) return (sx << (ew + mw)) | (emax << mw);
    if (ey == emax) return (sy << (ew + mw)) | (emax << mw);
    if (ex * (one << mw) + mx >= ey * (one << mw) + my) begin
      sbig = sx; ebig = ex; sigbig = (ex == 0) ? 0 : (one << mw) + mx;
      ssm = sy; esm = ey; sigsm = (ey == 0) ? 0 : (one << mw) + my;
    end else begin
      sbig = sy; ebig = ey; sigbig = (ey == 0) ? 0 : (one << mw) + my;
      ssm = sx; esm = ex; sigsm = (ex == 0) ? 0 : (one << mw) + mx;
    end
    d = ebig - esm;
    sigsm = (d > mw) ? 0 : (sigsm >> d);
    r = (sbig == ssm) ? sigbig + sigsm : sigbig - sigsm;
    if (r == 0) return 64'd0;
    e = ebig;
    while (r >= (one << (mw + 1))) begin r = r >> 1; e++; end
    while (r < (one << mw)) begin r = r << 1; e--; end
    if (e >= emax) return (sbig << (ew + mw)) | (emax << mw);
    if (e <= 0) return sbig << (ew + mw);
    return (sbig << (ew + mw)) | (e << mw) | (r - (one << mw));
  endfunction

  function automatic logic [63:0] rand_fp(input int ew, input int mw);
    longint emax, e, m, s;
    int k;
    emax = (longint'(1) << ew) - 1;
    k = $urandom_range(0, 19);
    m = longint'($urandom) & ((longint'(1) << mw) - 1);
    s = longint'($urandom_range(0, 1));
    if (k == 0) e = 0;
    else if (k == 1) begin e = emax; m = 0; end
    else if (k == 2) begin e = emax; m = m | 1; end
    else if (k == 3) e = emax - 1;
    else e = longint'($urandom_range(1, 32'(emax - 1)));
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  // Same exponent as x, fresh mantissa and sign: exercises cancellation.
  function automatic logic [63:0] rand_near(input logic [63:0] x, input int ew, input int mw);
    longint m, s;
    m = longint'($urandom) & ((longint'(1) << mw) - 1);
    s = longint'($urandom_range(0, 1));
    return (s << (ew + mw)) | ((longint'(x >> mw) & ((longint'(1) << ew) - 1)) << mw) | m;
  endfunction

  task automatic set_s(input logic c, input logic v, input logic [31:0] av, input logic [31:0] bv,
                       input logic s, input logic [3:0] t, input logic dir, input logic [31:0] dres);
    exp_t e;
    ce = c; in_valid = v; a = av; b = bv; sub = s; in_tag = t;
    if (c && v && !rst) begin
      e.res   = dir ? dres : 32'(ref_add(64'(av), 64'(bv), s, 8, 23));
      e.tag   = t;
      e.stamp = en_cnt + 1;
      q_s.push_back(e);
    end
  endtask

  task automatic set_h(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic s, input logic [3:0] t, input logic dir, input logic [15:0] dres);
    exp_t e;
    in_valid_h = v; a_h = av; b_h = bv; sub_h = s; in_tag_h = t;
    if (v && !rst) begin
      e.res   = dir ? 32'(dres) : 32'(ref_add(64'(av), 64'(bv), s, 5, 10));
      e.tag   = t;
      e.stamp = 0;
      q_h.push_back(e);
    end
  endtask

  task automatic rand_s(input logic c, input logic v, input logic [3:0] t);
    logic [31:0] av, bv;
    av = 32'(rand_fp(8, 23));
    bv = ($urandom_range(0, 3) == 0) ? 32'(rand_near(64'(av), 8, 23)) : 32'(rand_fp(8, 23));
    set_s(c, v, av, bv, 1'($urandom_range(0, 1)), t, 1'b0, 32'd0);
  endtask

  task automatic rand_h(input logic v);
    logic [15:0] av, bv;
    av = 16'(rand_fp(5, 10));
    bv = ($urandom_range(0, 3) == 0) ? 16'(rand_near(64'(av), 5, 10)) : 16'(rand_fp(5, 10));
    set_h(v, av, bv, 1'($urandom_range(0, 1)), 4'($urandom), 1'b0, 16'd0);
  endtask

  // Single-precision monitor: pops on every enabled edge that shows a result.
  initial begin : mon_s
    logic        ce_e, rst_e, pv;
    logic [31:0] pr;
    logic [3:0]  pt;
    exp_t        e;
    pv = 1'b0; pr = '0; pt = '0;
    forever begin
      @(posedge clk);
      ce_e = ce; rst_e = rst;
      if (ce_e) en_cnt++;
      #1;
      if (rst_e) begin
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_res", 64'(res), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
      end else if (!ce_e) begin
        check("hold_out_valid", 64'(out_valid), 64'(pv));
        check("hold_res", 64'(res), 64'(pr));
        check("hold_out_tag", 64'(out_tag), 64'(pt));
      end else if (out_valid) begin
        if (q_s.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_out: got res %h tag %0d, required no output", res, out_tag);
        end else begin
          e = q_s.pop_front();
          check("res", 64'(res), 64'(e.res));
          check("out_tag", 64'(out_tag), 64'(e.tag));
          check("latency", 64'(en_cnt - e.stamp), 64'd6);
        end
      end
      pv = out_valid; pr = res; pt = out_tag;
    end
  end

  // Half-precision monitor.
  initial begin : mon_h
    logic rst_e;
    exp_t e;
    forever begin
      @(posedge clk);
      rst_e = rst;
      #1;
      if (rst_e) begin
        check("h_rst_out_valid", 64'(out_valid_h), 64'd0);
      end else if (out_valid_h) begin
        if (q_h.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL h_unexpected_out: got res %h, required no output", res_h);
        end else begin
          e = q_h.pop_front();
          check("h_res", 64'(res_h), 64'(e.res));
          check("h_out_tag", 64'(out_tag_h), 64'(e.tag));
        end
      end
    end
  end

  logic [31:0] da[8] = '{32'h3F800000, 32'h3FC00000, 32'h3F800000, 32'h3F800000,
                         32'h7F7FFFFF, 32'h7F800000, 32'hFF800000, 32'hBF800000};
  logic [31:0] db[8] = '{32'h40000000, 32'hBF000000, 32'h3F800000, 32'h33800000,
                         32'h7F7FFFFF, 32'h7F800000, 32'h3F800000, 32'h3F800000};
  logic        ds[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
  logic [31:0] de[8] = '{32'h40400000, 32'h3F800000, 32'h00000000, 32'h3F800000,
                         32'h7F800000, 32'h7FC00000, 32'hFF800000, 32'h00000000};
  logic [15:0] ha[2] = '{16'h3C00, 16'h7BFF};
  logic [15:0] hb[2] = '{16'h4000, 16'h7BFF};
  logic [15:0] he[2] = '{16'h4200, 16'h7C00};

  initial begin : stim
    logic [3:0] k;
    rst = 1'b1; ce_h = 1'b1;
    set_s(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    set_h(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // directed vectors, first one carries tag 3
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_s(1'b1, 1'b1, da[i], db[i], ds[i], (i == 0) ? 4'd3 : 4'(i + 8), 1'b1, de[i]);
      if (i < 2) set_h(1'b1, ha[i], hb[i], 1'b0, 4'(i), 1'b1, he[i]);
      else set_h(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    end
    repeat (8) begin @(negedge clk); set_s(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0); set_h(1'b0, '0, '0, 1'b0, '0, 1'b0, '0); end

    // ten back-to-back ops, tags 0..9, ce low three cycles in the middle
    k = 4'd0;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      if (i >= 5 && i < 8) rand_s(1'b0, 1'b1, 4'hF);
      else begin rand_s(1'b1, 1'b1, k); k++; end
    end
    repeat (10) begin @(negedge clk); set_s(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0); end

    // reset with four operations in flight
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); rand_s(1'b1, 1'b1, 4'(i)); rand_h(1'b1);
    end
    @(negedge clk);
    rst = 1'b1;
    q_s.delete(); q_h.delete();
    rand_s(1'b1, 1'b1, 4'd7); rand_h(1'b1);
    @(negedge clk);
    rst = 1'b0;
    set_s(1'b1, 1'b1, 32'h40000000, 32'h40400000, 1'b0, 4'd5, 1'b1, 32'h40A00000);
    set_h(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    repeat (10) begin @(negedge clk); set_s(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0); end

    // randomized traffic with ce and in_valid gaps
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      rand_s(1'($urandom_range(0, 99) < 85), 1'($urandom_range(0, 99) < 70), 4'($urandom));
      rand_h(1'($urandom_range(0, 99) < 60));
    end
    repeat (14) begin
      @(negedge clk);
      set_s(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
      set_h(1'b0, '0, '0, 1'b0, '0, 1'b0, '0);
    end

    n_tests++;
    if (q_s.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results still pending, required 0", q_s.size());
    end
    n_tests++;
    if (q_h.size() != 0) begin
      n_fail++;
      $display("FAIL h_drain: %0d results still pending, required 0", q_h.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
